// File: rtl/vga_sprite_renderer.sv
// VGA 640x480@60 timing, world sprite lookup and sprite ROM fetch, aligned in a 2-tick pixel pipeline.
// Optional feature macro: GRID_OVERLAY_EN draws 32-px cell grid lines inside the playfield.
module vga_sprite_renderer #(
  parameter int          H_VISIBLE  = 640,
  parameter int          H_FP       = 16,
  parameter int          H_SYNC     = 96,
  parameter int          H_BP       = 48,
  parameter int          V_VISIBLE  = 480,
  parameter int          V_FP       = 10,
  parameter int          V_SYNC     = 2,
  parameter int          V_BP       = 33,
  parameter int          FIELD_ROWS = 10,
  parameter logic [23:0] BORDER_RGB = 24'h202040
) (
  input  logic        clock_50,
  input  logic        reset,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  input  logic [3:0]  sprite,
  output logic [13:0] rom_addr,
  input  logic [7:0]  rom_data,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        vga_hs_n,
  output logic        vga_vs_n,
  output logic        vga_blank_n,
  output logic        vga_sync_n,
  output logic        vga_clk,
  output logic        frame_tick
);

  localparam logic [9:0]  H_LAST    = 10'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0]  V_LAST    = 10'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0]  H_VIS     = 10'(H_VISIBLE);
  localparam logic [9:0]  V_VIS     = 10'(V_VISIBLE);
  localparam logic [9:0]  HS_START  = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0]  HS_END    = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0]  VS_START  = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0]  VS_END    = 10'(V_VISIBLE + V_FP + V_SYNC);
  localparam logic [9:0]  FIELD_END = 10'(FIELD_ROWS * 32);

  logic phase_r;
  logic pix_en_s;
  logic h_wrap_s;
  logic v_wrap_s;
  logic visible_s;
  logic in_field_s;
  logic hs_s;
  logic vs_s;
  logic s1_visible_r;
  logic s1_in_field_r;
  logic s1_hs_r;
  logic s1_vs_r;
  logic [23:0] rgb_s;
`ifdef GRID_OVERLAY_EN
  logic grid_s;
  logic s1_grid_r;
`endif

  assign pix_en_s   = phase_r;
  assign vga_clk    = phase_r;
  assign vga_sync_n = 1'b0;
  assign h_wrap_s   = (pixel_x == H_LAST);
  assign v_wrap_s   = (pixel_y == V_LAST);

  // Stage-0 flags derived from the live counters
  assign visible_s  = (pixel_x < H_VIS) && (pixel_y < V_VIS);
  assign in_field_s = visible_s && (pixel_y < FIELD_END);
  assign hs_s       = (pixel_x >= HS_START) && (pixel_x < HS_END);
  assign vs_s       = (pixel_y >= VS_START) && (pixel_y < VS_END);
`ifdef GRID_OVERLAY_EN
  assign grid_s     = (pixel_x[4:0] == 5'd0) || (pixel_y[4:0] == 5'd0);
`endif

  // Pixel-clock phase: every second clock_50 cycle is a pixel tick
  always_ff @(posedge clock_50) begin
    if (reset) phase_r <= 1'b0;
    else       phase_r <= ~phase_r;
  end

  // Stage 0: beam counters double as pixel_x/pixel_y; frame_tick marks the full wrap
  always_ff @(posedge clock_50) begin
    if (reset) begin
      pixel_x    <= 10'd0;
      pixel_y    <= 10'd0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= pix_en_s && h_wrap_s && v_wrap_s;
      if (pix_en_s) begin
        if (h_wrap_s) begin
          pixel_x <= 10'd0;
          pixel_y <= v_wrap_s ? 10'd0 : pixel_y + 10'd1;
        end else begin
          pixel_x <= pixel_x + 10'd1;
        end
      end
    end
  end

  // Stage 1: ROM address from the world's sprite code, flags delayed one tick
  always_ff @(posedge clock_50) begin
    if (reset) begin
      rom_addr      <= 14'd0;
      s1_visible_r  <= 1'b0;
      s1_in_field_r <= 1'b0;
      s1_hs_r       <= 1'b0;
      s1_vs_r       <= 1'b0;
`ifdef GRID_OVERLAY_EN
      s1_grid_r     <= 1'b0;
`endif
    end else if (pix_en_s) begin
      rom_addr      <= {sprite, pixel_y[4:0], pixel_x[4:0]};
      s1_visible_r  <= visible_s;
      s1_in_field_r <= in_field_s;
      s1_hs_r       <= hs_s;
      s1_vs_r       <= vs_s;
`ifdef GRID_OVERLAY_EN
      s1_grid_r     <= grid_s;
`endif
    end
  end

  // Colour select: RGB332 texel widened by bit replication, border, or black
  always_comb begin
    rgb_s = 24'h000000;
    if (s1_in_field_r) begin
`ifdef GRID_OVERLAY_EN
      if (s1_grid_r) begin
        rgb_s = 24'h404040;
      end else begin
        rgb_s = {rom_data[7:5], rom_data[7:5], rom_data[7:6],
                 rom_data[4:2], rom_data[4:2], rom_data[4:3],
                 {4{rom_data[1:0]}}};
      end
`else
      rgb_s = {rom_data[7:5], rom_data[7:5], rom_data[7:6],
               rom_data[4:2], rom_data[4:2], rom_data[4:3],
               {4{rom_data[1:0]}}};
`endif
    end else if (s1_visible_r) begin
      rgb_s = BORDER_RGB;
    end else begin
      rgb_s = 24'h000000;
    end
  end

  // Stage 2: registered DAC outputs, syncs kept aligned with colour
  always_ff @(posedge clock_50) begin
    if (reset) begin
      vga_r       <= 8'd0;
      vga_g       <= 8'd0;
      vga_b       <= 8'd0;
      vga_hs_n    <= 1'b1;
      vga_vs_n    <= 1'b1;
      vga_blank_n <= 1'b0;
    end else if (pix_en_s) begin
      {vga_r, vga_g, vga_b} <= rgb_s;
      vga_hs_n    <= ~s1_hs_r;
      vga_vs_n    <= ~s1_vs_r;
      vga_blank_n <= s1_visible_r;
    end
  end

endmodule
